// File: rtl/rgb_word_packer_pkg.sv
// Shared image-path constants: pixel/word widths and packer state encodings.
package rgb_word_packer_pkg;

  localparam int PIX_W  = 24;
  localparam int WORD_W = 32;

  // State name = bytes still held in the accumulator after the last pixel
  localparam logic [1:0] ST_H0 = 2'd0;
  localparam logic [1:0] ST_H3 = 2'd1;
  localparam logic [1:0] ST_H2 = 2'd2;
  localparam logic [1:0] ST_H1 = 2'd3;

endpackage

// File: rtl/rgb_word_packer_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; head visible while non-empty, zero otherwise.
// A pop frees space before the push in the same cycle, so full+push+pop never drops.
module sync_fifo_sa #(
  parameter int W     = 33,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [W-1:0]  i_push_dat,
  input  logic          i_pop,
  output logic [W-1:0]  o_dat,
  output logic          o_vld,
  output logic [AW:0]   o_count,
  output logic          o_drop
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_count;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_pop   = i_pop & ~w_empty;
  assign w_push  = i_push & (~w_full | w_pop);
  assign o_drop  = i_push & w_full & ~w_pop;

  assign o_vld   = ~w_empty;
  assign o_dat   = w_empty ? '0 : r_mem[r_rd];
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr] <= i_push_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/rgb_word_packer.sv
// Packs RGB888 pixels into 32-bit little-endian words (4 pixels -> 3 words) into a show-ahead FIFO.
// Word visible one cycle after its completing pixel; input never stalls, drops on full are sticky-flagged.
module rgb_word_packer
  import rgb_word_packer_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    r_in,
  input  logic [7:0]                    g_in,
  input  logic [7:0]                    b_in,
  input  logic                          data_valid,
  input  logic                          frame_end,
  output logic [WORD_W-1:0]             word_out,
  output logic                          word_valid,
  output logic                          word_last,
  input  logic                          word_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  logic [1:0]       r_state;
  logic [PIX_W-1:0] r_acc;
  logic [PIX_W-1:0] r_flush;
  logic             r_flush_vld;
  logic             r_overflow;

  logic [1:0]        w_state_nxt;
  logic [PIX_W-1:0]  w_acc_nxt;
  logic              w_pix_push;
  logic [WORD_W-1:0] w_pix_word;
  logic              w_fe;
  logic              w_flush_take;
  logic              w_push;
  logic [WORD_W:0]   w_push_dat;
  logic [WORD_W:0]   w_head;
  logic              w_drop;

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_pix_push  = 1'b0;
    w_pix_word  = '0;
    if (data_valid) begin
      case (r_state)
        ST_H0: begin
          w_acc_nxt   = {b_in, g_in, r_in};
          w_state_nxt = ST_H3;
        end
        ST_H3: begin
          w_pix_push  = 1'b1;
          w_pix_word  = {r_in, r_acc};
          w_acc_nxt   = {8'h00, b_in, g_in};
          w_state_nxt = ST_H2;
        end
        ST_H2: begin
          w_pix_push  = 1'b1;
          w_pix_word  = {g_in, r_in, r_acc[15:0]};
          w_acc_nxt   = {16'h0000, b_in};
          w_state_nxt = ST_H1;
        end
        default: begin
          w_pix_push  = 1'b1;
          w_pix_word  = {b_in, g_in, r_in, r_acc[7:0]};
          w_acc_nxt   = '0;
          w_state_nxt = ST_H0;
        end
      endcase
    end
  end

  // Residual bytes only exist when the frame ends off a word boundary
  assign w_fe         = data_valid & frame_end;
  assign w_flush_take = w_fe & (w_state_nxt != ST_H0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_H0;
      r_acc       <= '0;
      r_flush     <= '0;
      r_flush_vld <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_flush_vld <= w_flush_take;
      if (w_flush_take) begin
        r_flush <= w_acc_nxt;
        r_acc   <= '0;
        r_state <= ST_H0;
      end else begin
        r_acc   <= w_acc_nxt;
        r_state <= w_state_nxt;
      end
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // The flush cycle always starts from H0, so it never collides with a pixel push
  assign w_push     = r_flush_vld | w_pix_push;
  assign w_push_dat = r_flush_vld ? {1'b1, 8'h00, r_flush}
                                  : {w_fe & (w_state_nxt == ST_H0), w_pix_word};

  sync_fifo_sa #(
    .W     (WORD_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (word_ready),
    .o_dat      (w_head),
    .o_vld      (word_valid),
    .o_count    (fifo_level),
    .o_drop     (w_drop)
  );

  assign word_out  = w_head[WORD_W-1:0];
  assign word_last = w_head[WORD_W];
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_rgb_word_packer.sv
// Directed bench for rgb_word_packer: packing order, frame-end flush, FIFO full/overflow behaviour.
module tb_rgb_word_packer;

  localparam int DEPTH = 8;

  logic        clk;
  logic        rst_n;
  logic [7:0]  r_in, g_in, b_in;
  logic        data_valid;
  logic        frame_end;
  logic [31:0] word_out;
  logic        word_valid;
  logic        word_last;
  logic        word_ready;
  logic [3:0]  fifo_level;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;

  rgb_word_packer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .r_in       (r_in),
    .g_in       (g_in),
    .b_in       (b_in),
    .data_valid (data_valid),
    .frame_end  (frame_end),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_last  (word_last),
    .word_ready (word_ready),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Holds one pixel for a single cycle; returns #1 after the capturing edge
  task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b, input logic fe);
    r_in = r; g_in = g; b_in = b;
    data_valid = 1'b1;
    frame_end  = fe;
    @(posedge clk); #1;
    data_valid = 1'b0;
    frame_end  = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  function automatic logic [7:0] sb(input int k);
    return 8'(k);
  endfunction

  function automatic logic [31:0] seq_word(input int w);
    return {sb(4*w+3), sb(4*w+2), sb(4*w+1), sb(4*w)};
  endfunction

  initial begin
    rst_n = 1'b0; r_in = '0; g_in = '0; b_in = '0;
    data_valid = 1'b0; frame_end = 1'b0; word_ready = 1'b0;

    // 1: reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_word_out", word_out, 32'h0);
    chk("rst_word_valid", 32'(word_valid), 32'h0);
    chk("rst_word_last", 32'(word_last), 32'h0);
    chk("rst_fifo_level", 32'(fifo_level), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    rst_n = 1'b1;
    repeat (3) idle();
    chk("idle_word_valid", 32'(word_valid), 32'h0);

    // 2: four pixels -> three words
    word_ready = 1'b1;
    send(8'h11, 8'h22, 8'h33, 1'b0);
    chk("p1_no_word", 32'(word_valid), 32'h0);
    send(8'h44, 8'h55, 8'h66, 1'b0);
    chk("w0_data", word_out, 32'h44332211);
    chk("w0_valid", 32'(word_valid), 32'h1);
    chk("w0_last", 32'(word_last), 32'h0);
    send(8'h77, 8'h88, 8'h99, 1'b0);
    chk("w1_data", word_out, 32'h88776655);
    send(8'hAA, 8'hBB, 8'hCC, 1'b0);
    chk("w2_data", word_out, 32'hCCBBAA99);
    chk("w2_last", 32'(word_last), 32'h0);
    idle();
    chk("drained_valid", 32'(word_valid), 32'h0);
    chk("drained_level", 32'(fifo_level), 32'h0);

    // 3: single-pixel frame flushes on cycle+2
    send(8'h01, 8'h02, 8'h03, 1'b1);
    chk("fe1_not_yet", 32'(word_valid), 32'h0);
    idle();
    chk("fe1_data", word_out, 32'h00030201);
    chk("fe1_last", 32'(word_last), 32'h1);
    idle();
    chk("fe1_popped", 32'(word_valid), 32'h0);

    // 4: two-pixel frame, next frame starts in the flush cycle
    send(8'h11, 8'h22, 8'h33, 1'b0);
    send(8'h44, 8'h55, 8'h66, 1'b1);
    chk("fe2_w0_data", word_out, 32'h44332211);
    chk("fe2_w0_last", 32'(word_last), 32'h0);
    send(8'h01, 8'h02, 8'h03, 1'b0);
    chk("fe2_flush_data", word_out, 32'h00006655);
    chk("fe2_flush_last", 32'(word_last), 32'h1);
    send(8'h04, 8'h05, 8'h06, 1'b0);
    chk("nf_w0_data", word_out, 32'h04030201);
    chk("nf_w0_last", 32'(word_last), 32'h0);
    send(8'h07, 8'h08, 8'h09, 1'b0);
    chk("nf_w1_data", word_out, 32'h08070605);
    send(8'h0A, 8'h0B, 8'h0C, 1'b1);
    chk("nf_w2_data", word_out, 32'h0C0B0A09);
    chk("nf_w2_last", 32'(word_last), 32'h1);
    idle();
    chk("nf_popped", 32'(word_valid), 32'h0);

    // 5: overflow with 9 words into 8 slots
    word_ready = 1'b0;
    for (int p = 0; p < 12; p++) send(sb(3*p), sb(3*p+1), sb(3*p+2), 1'b0);
    chk("ovf_level", 32'(fifo_level), 32'(DEPTH));
    chk("ovf_flag", 32'(overflow), 32'h1);
    word_ready = 1'b1;
    for (int w = 0; w < DEPTH; w++) begin
      chk($sformatf("ovf_drain_%0d", w), word_out, seq_word(w));
      idle();
    end
    chk("ovf_drained", 32'(word_valid), 32'h0);
    chk("ovf_sticky", 32'(overflow), 32'h1);

    // 6: full FIFO with push and pop together
    word_ready = 1'b0;
    rst_n = 1'b0;
    idle();
    chk("rst2_overflow", 32'(overflow), 32'h0);
    rst_n = 1'b1;
    idle();
    for (int p = 0; p < 11; p++) send(sb(3*p), sb(3*p+1), sb(3*p+2), 1'b0);
    chk("full_level", 32'(fifo_level), 32'(DEPTH));
    chk("full_no_ovf", 32'(overflow), 32'h0);
    word_ready = 1'b1;
    send(sb(33), sb(34), sb(35), 1'b0);
    word_ready = 1'b0;
    chk("pp_level", 32'(fifo_level), 32'(DEPTH));
    chk("pp_no_ovf", 32'(overflow), 32'h0);
    word_ready = 1'b1;
    for (int w = 1; w <= DEPTH; w++) begin
      chk($sformatf("pp_drain_%0d", w), word_out, seq_word(w));
      idle();
    end
    chk("pp_drained", 32'(word_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
